// File: rtl/alu_op_queue_if.sv
// Request, ALU-side and result handshake bundle for alu_op_queue.
// slave is the queue itself; master is the producer/ALU/consumer side.
interface alu_op_queue_if #(
   parameter int WIDTH = 64,
   parameter int OPW   = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [OPW-1:0]   in_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_carry;
   logic [OPW-1:0]   out_op;
   logic             out_divz;

   modport slave (
      input  in_valid, in_a, in_b, in_op, alu_result, alu_carry, out_ready,
      output in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_carry, out_op, out_divz
   );

   modport master (
      output in_valid, in_a, in_b, in_op, alu_result, alu_carry, out_ready,
      input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_carry, out_op, out_divz
   );
endinterface

// File: rtl/alu_op_queue.sv
// DEPTH-entry operand/command FIFO feeding an external ALU, with a registered result stage.
// Optional macro ALU_OP_QUEUE_DIVZ_CHECK_EN: saturate divide-by-zero results and flag them on out_divz.
module alu_op_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   parameter int OPW   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   alu_op_queue_if.slave                bus,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [OPW-1:0] OP_DIV = OPW'(4'b0011);

   logic [WIDTH-1:0] r_mem_a  [DEPTH];
   logic [WIDTH-1:0] r_mem_b  [DEPTH];
   logic [OPW-1:0]   r_mem_op [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_result;
   logic             r_out_carry;
   logic [OPW-1:0]   r_out_op;
   logic             r_out_divz;

   logic             w_push;
   logic             w_pop;
   logic             w_in_ready;
   logic [WIDTH-1:0] w_head_a;
   logic [WIDTH-1:0] w_head_b;
   logic [OPW-1:0]   w_head_op;
   logic [WIDTH-1:0] w_cap_result;
   logic             w_cap_carry;
   logic             w_cap_divz;

   // Full blocks pushes outright; a same-cycle pop never frees a slot for a push.
   assign w_in_ready = (r_count < CW'(DEPTH)) && !reset;
   assign w_push     = bus.in_valid && w_in_ready;
   assign w_pop      = (r_count != '0) && (!r_out_valid || bus.out_ready);

   assign w_head_a   = r_mem_a[r_rd_ptr];
   assign w_head_b   = r_mem_b[r_rd_ptr];
   assign w_head_op  = r_mem_op[r_rd_ptr];

   // Head entry drives the ALU; zeros when the queue is empty.
   always_comb begin
      bus.alu_a  = '0;
      bus.alu_b  = '0;
      bus.alu_op = '0;
      if (r_count != '0) begin
         bus.alu_a  = w_head_a;
         bus.alu_b  = w_head_b;
         bus.alu_op = w_head_op;
      end else begin
         bus.alu_a  = '0;
         bus.alu_b  = '0;
         bus.alu_op = '0;
      end
   end

   // Value captured into the result register on a pop.
   always_comb begin
      w_cap_result = bus.alu_result;
      w_cap_carry  = bus.alu_carry;
      w_cap_divz   = 1'b0;
`ifdef ALU_OP_QUEUE_DIVZ_CHECK_EN
      if ((w_head_op == OP_DIV) && (w_head_b == '0)) begin
         w_cap_result = '1;
         w_cap_carry  = 1'b0;
         w_cap_divz   = 1'b1;
      end else begin
         w_cap_result = bus.alu_result;
         w_cap_carry  = bus.alu_carry;
         w_cap_divz   = 1'b0;
      end
`else
      if (w_head_op == OP_DIV) begin
         w_cap_divz = 1'b0;
      end else begin
         w_cap_divz = 1'b0;
      end
`endif
   end

   // Storage is deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr]  <= bus.in_a;
         r_mem_b[r_wr_ptr]  <= bus.in_b;
         r_mem_op[r_wr_ptr] <= bus.in_op;
      end else begin
         r_mem_a[r_wr_ptr]  <= r_mem_a[r_wr_ptr];
         r_mem_b[r_wr_ptr]  <= r_mem_b[r_wr_ptr];
         r_mem_op[r_wr_ptr] <= r_mem_op[r_wr_ptr];
      end
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Result register: load on pop, drop valid once consumed with nothing behind it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_carry  <= 1'b0;
         r_out_op     <= '0;
         r_out_divz   <= 1'b0;
      end else if (w_pop) begin
         r_out_valid  <= 1'b1;
         r_out_result <= w_cap_result;
         r_out_carry  <= w_cap_carry;
         r_out_op     <= w_head_op;
         r_out_divz   <= w_cap_divz;
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid  <= 1'b0;
      end else begin
         r_out_valid  <= r_out_valid;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_result = r_out_result;
   assign bus.out_carry  = r_out_carry;
   assign bus.out_op     = r_out_op;
   assign bus.out_divz   = r_out_divz;
   assign count          = r_count;
endmodule

// File: tb/tb_alu_op_queue.sv
// Directed bench for alu_op_queue: queue-based reference model checked every cycle plus literal checks.
module tb_alu_op_queue;
   localparam int DEPTH = 4;

   logic       clk;
   logic       reset;
   logic [2:0] count;
   int         n_checks;
   int         n_errors;
   bit         cmp_en;

   alu_op_queue_if #(.WIDTH(64), .OPW(4)) bus ();

   alu_op_queue #(.DEPTH(DEPTH), .WIDTH(64), .OPW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in ALU: add with carry, sub, and, div (div by zero yields 0), xor.
   function automatic logic [64:0] alu_fn(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
      case (op)
         4'b0000: return {1'b0, a} + {1'b0, b};
         4'b0001: return {1'b0, a - b};
         4'b0010: return {1'b0, a & b};
         4'b0011: return (b == 64'd0) ? 65'd0 : {1'b0, a / b};
         default: return {1'b0, a ^ b};
      endcase
   endfunction

   always_comb {bus.alu_carry, bus.alu_result} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of accepted requests plus the result register contents.
   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  op;
   } req_t;
   req_t        mq[$];
   logic        m_valid  = 1'b0;
   logic [63:0] m_result = 64'd0;
   logic        m_carry  = 1'b0;
   logic [3:0]  m_op     = 4'd0;
   logic        m_divz   = 1'b0;

   always @(posedge clk) begin
      bit   do_pop;
      bit   do_push;
      req_t h;
      req_t n;
      logic [64:0] r;
      if (reset) begin
         mq.delete();
         m_valid = 1'b0; m_result = 64'd0; m_carry = 1'b0; m_op = 4'd0; m_divz = 1'b0;
      end else begin
         do_pop  = (mq.size() > 0) && (!m_valid || bus.out_ready);
         do_push = bus.in_valid && (mq.size() < DEPTH);
         if (do_pop) begin
            h = mq.pop_front();
            r = alu_fn(h.a, h.b, h.op);
            m_valid = 1'b1; m_result = r[63:0]; m_carry = r[64]; m_op = h.op; m_divz = 1'b0;
`ifdef ALU_OP_QUEUE_DIVZ_CHECK_EN
            if (h.op == 4'b0011 && h.b == 64'd0) begin
               m_result = '1; m_carry = 1'b0; m_divz = 1'b1;
            end
`endif
         end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
         end
         if (do_push) begin
            n.a = bus.in_a; n.b = bus.in_b; n.op = bus.in_op;
            mq.push_back(n);
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("count", 64'(count), 64'(mq.size()));
         check("in_ready", 64'(bus.in_ready), 64'(!reset && (mq.size() < DEPTH)));
         check("out_valid", 64'(bus.out_valid), 64'(m_valid));
         check("out_result", bus.out_result, m_result);
         check("out_carry", 64'(bus.out_carry), 64'(m_carry));
         check("out_op", 64'(bus.out_op), 64'(m_op));
         check("out_divz", 64'(bus.out_divz), 64'(m_divz));
         check("alu_a", bus.alu_a, (mq.size() > 0) ? mq[0].a : 64'd0);
         check("alu_b", bus.alu_b, (mq.size() > 0) ? mq[0].b : 64'd0);
         check("alu_op", 64'(bus.alu_op), (mq.size() > 0) ? 64'(mq[0].op) : 64'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
      bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_op = op;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_errors = 0; cmp_en = 1'b0;
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_a = 64'd0; bus.in_b = 64'd0; bus.in_op = 4'd0;
      bus.out_ready = 1'b0;
      tick();
      cmp_en = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // single request and carry
      bus.out_ready = 1'b1;
      push(64'd5, 64'd3, 4'b0000);
      tick();
      check("single_valid", 64'(bus.out_valid), 64'd1);
      check("single_result", bus.out_result, 64'd8);
      check("single_carry", 64'(bus.out_carry), 64'd0);
      tick();
      check("single_one_beat", 64'(bus.out_valid), 64'd0);
      push(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000);
      tick();
      check("carry_result", bus.out_result, 64'd0);
      check("carry_carry", 64'(bus.out_carry), 64'd1);
      tick();

      // fill under backpressure, stall, then drain
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(64'(10 + i), 64'(i), 4'b0001);
      check("fill_count", 64'(count), 64'd4);
      check("fill_in_ready", 64'(bus.in_ready), 64'd0);
      check("fill_head_result", bus.out_result, 64'd10);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_result", bus.out_result, 64'd10);
         check("stall_op", 64'(bus.out_op), 64'd1);
         check("stall_valid", 64'(bus.out_valid), 64'd1);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("drain_valid", 64'(bus.out_valid), 64'd1);
         check("drain_result", bus.out_result, 64'd10);
      end
      check("drain_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      check("drain_done", 64'(bus.out_valid), 64'd0);

      // reset mid-stream
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(64'(i + 1), 64'd1, 4'b0000);
      check("pre_rst_count", 64'(count), 64'd3);
      check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_result", bus.out_result, 64'd0);
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_stale", 64'(bus.out_valid), 64'd0);
      end

      // divide by zero
      push(64'd100, 64'd0, 4'b0011);
      tick();
`ifdef ALU_OP_QUEUE_DIVZ_CHECK_EN
      check("divz_result", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFF);
      check("divz_flag", 64'(bus.out_divz), 64'd1);
`else
      check("divz_result", bus.out_result, 64'd0);
      check("divz_flag", 64'(bus.out_divz), 64'd0);
`endif
      push(64'd100, 64'd4, 4'b0011);
      tick();
      check("div_result", bus.out_result, 64'd25);
      check("div_flag", 64'(bus.out_divz), 64'd0);

      // mixed stream with intermittent backpressure (model-checked each cycle)
      for (int i = 0; i < 48; i++) begin
         bus.in_valid  = ((i % 4) != 3);
         bus.in_a      = 64'(i * 3 + 1);
         bus.in_b      = 64'(i % 5);
         bus.in_op     = 4'((i / 2) % 4);
         bus.out_ready = ((i % 6) < 3) || ((i % 11) == 7);
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (8) tick();
      check("final_empty", 64'(count), 64'd0);
      check("final_valid", 64'(bus.out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
